// File: rtl/ccc_pkg.sv
// Shared definitions for the cruise-control command front end: command codes,
// speed width and the bit positions of the seven debounced driver inputs.
package ccc_pkg;

  localparam int SPD_W = 7;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_SET    = 3'd1,
    CMD_ACCEL  = 3'd2,
    CMD_COAST  = 3'd3,
    CMD_CANCEL = 3'd4,
    CMD_RESUME = 3'd5
  } cmd_e;

  localparam int N_IN       = 7;
  localparam int IDX_THR    = 0;
  localparam int IDX_BRAKE  = 1;
  localparam int IDX_SET    = 2;
  localparam int IDX_ACCEL  = 3;
  localparam int IDX_COAST  = 4;
  localparam int IDX_CANCEL = 5;
  localparam int IDX_RESUME = 6;

endpackage

// File: rtl/ccc_debounce.sv
// One raw driver input: two-flop synchronizer, consecutive-difference counter,
// debounced level and a one-cycle pulse on the debounced rising edge.
module ccc_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_deb;
  logic       r_rise;
  logic [7:0] r_cnt;
  logic       w_diff;
  logic       w_flip;

  assign w_diff = r_s2 ^ r_deb;
  // The level only moves once the count has already reached DB_CYCLES and the
  // synchronized value still disagrees, so a DB_CYCLES-long glitch is filtered.
  assign w_flip = w_diff && (r_cnt == 8'(DB_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_deb  <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= w_flip & r_s2;
      if (w_flip) begin
        r_deb <= r_s2;
        r_cnt <= 8'd0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign o_level = r_deb;
  assign o_rise  = r_rise;

endmodule

// File: rtl/ccc_cmd_gen.sv
// Driver-side front end for ccc: debounces pedals/buttons and issues one-hot
// command pulses. Optional auto-repeat of accel/coast under CCC_AUTOREPEAT_EN.
module ccc_cmd_gen
  import ccc_pkg::*;
#(
  parameter int               DB_CYCLES   = 4,
  parameter logic [SPD_W-1:0] MIN_SET_SPD = 7'd40,
  parameter int               RPT_DLY     = 32,
  parameter int               RPT_PER     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_throttle,
  input  logic             raw_brake,
  input  logic             raw_set,
  input  logic             raw_accel,
  input  logic             raw_coast,
  input  logic             raw_cancel,
  input  logic             raw_resume,
  input  logic [SPD_W-1:0] spd,
  output logic             throttle,
  output logic             brake,
  output logic             set,
  output logic             accel,
  output logic             coast,
  output logic             cancel,
  output logic             resume,
  output logic [2:0]       cmd_code,
  output logic             set_rejected
);

  logic [N_IN-1:0] w_raw;
  logic [N_IN-1:0] w_lvl;
  logic [N_IN-1:0] w_rise;

  assign w_raw = {raw_resume, raw_cancel, raw_coast, raw_accel, raw_set, raw_brake, raw_throttle};

  for (genvar g = 0; g < N_IN; g++) begin : g_db
    ccc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_level (w_lvl[g]),
      .o_rise  (w_rise[g])
    );
  end

  logic w_lock;
  logic w_rpt_accel, w_rpt_coast;
  logic w_rq_cancel, w_rq_set, w_rq_resume, w_rq_accel, w_rq_coast;
  logic w_iss_cancel, w_iss_set, w_iss_resume, w_iss_accel, w_iss_coast, w_rej;

  assign w_lock      = w_lvl[IDX_BRAKE];
  assign w_rq_cancel = w_rise[IDX_CANCEL];
  assign w_rq_set    = w_rise[IDX_SET] & ~w_lock;
  assign w_rq_resume = w_rise[IDX_RESUME] & ~w_lock;
  assign w_rq_accel  = (w_rise[IDX_ACCEL] | w_rpt_accel) & ~w_lock;
  assign w_rq_coast  = (w_rise[IDX_COAST] | w_rpt_coast) & ~w_lock;

  // A set that wins but is too slow still consumes the cycle: lower requests drop.
  always_comb begin
    w_iss_cancel = 1'b0;
    w_iss_set    = 1'b0;
    w_iss_resume = 1'b0;
    w_iss_accel  = 1'b0;
    w_iss_coast  = 1'b0;
    w_rej        = 1'b0;
    if (w_rq_cancel) begin
      w_iss_cancel = 1'b1;
    end else if (w_rq_set) begin
      if (spd >= MIN_SET_SPD) w_iss_set = 1'b1;
      else                    w_rej     = 1'b1;
    end else if (w_rq_resume) begin
      w_iss_resume = 1'b1;
    end else if (w_rq_accel) begin
      w_iss_accel = 1'b1;
    end else if (w_rq_coast) begin
      w_iss_coast = 1'b1;
    end
  end

  logic w_unused_common;
  assign w_unused_common = ^{w_lvl[IDX_SET], w_lvl[IDX_CANCEL], w_lvl[IDX_RESUME],
                             w_rise[IDX_THR], w_rise[IDX_BRAKE]};

`ifdef CCC_AUTOREPEAT_EN
  logic        r_rpt_on;
  logic [15:0] r_rpt_cnt;
  logic        w_rpt_active;
  logic        w_rpt_hit;
  logic        w_from_rpt;

  assign w_rpt_active = (w_lvl[IDX_ACCEL] | w_lvl[IDX_COAST]) & ~w_lock;
  assign w_rpt_hit    = r_rpt_on & w_rpt_active & (r_rpt_cnt == 16'(RPT_DLY - 1));
  assign w_rpt_accel  = w_rpt_hit & w_lvl[IDX_ACCEL];
  assign w_rpt_coast  = w_rpt_hit & ~w_lvl[IDX_ACCEL] & w_lvl[IDX_COAST];
  assign w_from_rpt   = w_iss_accel ? ~w_rise[IDX_ACCEL] : ~w_rise[IDX_COAST];

  // After a repeat the count restarts part-way so the next hit is RPT_PER away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_on  <= 1'b0;
      r_rpt_cnt <= 16'd0;
    end else if (w_iss_accel | w_iss_coast) begin
      r_rpt_on  <= 1'b1;
      r_rpt_cnt <= w_from_rpt ? 16'(RPT_DLY - RPT_PER) : 16'd0;
    end else if (~w_rpt_active | w_iss_cancel | w_iss_set | w_iss_resume) begin
      r_rpt_on  <= 1'b0;
      r_rpt_cnt <= 16'd0;
    end else if (r_rpt_on) begin
      r_rpt_cnt <= r_rpt_cnt + 16'd1;
    end
  end
`else
  logic w_unused_rpt;
  assign w_rpt_accel  = 1'b0;
  assign w_rpt_coast  = 1'b0;
  // Levels and timing parameters only consumed by the auto-repeat logic.
  assign w_unused_rpt = ^{w_lvl[IDX_ACCEL], w_lvl[IDX_COAST], RPT_DLY[0], RPT_PER[0]};
`endif

  logic r_throttle, r_brake, r_set, r_accel, r_coast, r_cancel, r_resume, r_rej;
  cmd_e r_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_throttle <= 1'b0;
      r_brake    <= 1'b0;
      r_set      <= 1'b0;
      r_accel    <= 1'b0;
      r_coast    <= 1'b0;
      r_cancel   <= 1'b0;
      r_resume   <= 1'b0;
      r_rej      <= 1'b0;
      r_cmd      <= CMD_NONE;
    end else begin
      r_throttle <= w_lvl[IDX_THR];
      r_brake    <= w_lvl[IDX_BRAKE];
      r_set      <= w_iss_set;
      r_accel    <= w_iss_accel;
      r_coast    <= w_iss_coast;
      r_cancel   <= w_iss_cancel;
      r_resume   <= w_iss_resume;
      r_rej      <= w_rej;
      if (w_iss_cancel)      r_cmd <= CMD_CANCEL;
      else if (w_iss_set)    r_cmd <= CMD_SET;
      else if (w_iss_resume) r_cmd <= CMD_RESUME;
      else if (w_iss_accel)  r_cmd <= CMD_ACCEL;
      else if (w_iss_coast)  r_cmd <= CMD_COAST;
    end
  end

  assign throttle     = r_throttle;
  assign brake        = r_brake;
  assign set          = r_set;
  assign accel        = r_accel;
  assign coast        = r_coast;
  assign cancel       = r_cancel;
  assign resume       = r_resume;
  assign set_rejected = r_rej;
  assign cmd_code     = r_cmd;

endmodule
